decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage for the 9-bit accumulator-style core. It sits between fetch and execute and accepts one instruction per cycle over a valid/ready handshake. It emits registered control and register-address fields, with a one-entry output register. It adds behaviour the combinational decoder lacks: a sticky halt latch, a load-use interlock, and a saturating stall counter.

## Interface
- REG_WIDTH, 8, datapath/immediate width
- NUM_REGS, 12, register-file depth (≥12); address width RA_W = $clog2(NUM_REGS)
- STALL_CNT_W, 16, width of stall counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  fetch presents instruction
- instruction  in  9  instruction word
- instr_ready  out  1  stage accepts this cycle
- out_ready  in  1  execute accepts output register
- out_valid  out  1  output register holds a decoded instruction
- alu_op  out  4  ALU operation
- rs_addr, rt_addr, rd_addr  out  RA_W  register addresses
- imm  out  REG_WIDTH  zero-extended immediate
- reg_write, sel_imm, mem_read, mem_write, mem2reg  out  1 each  control
- halted  out  1  sticky, HALT has been accepted
- stall_count  out  STALL_CNT_W  load-use stall cycles, saturating

## Operation
- Decode on op = instruction[8:6], sub = [1:0].
- Default fields: rs = {0,[5:4]}+4, rt = {0,[3:2]}, rd = 11, imm = 0, sel_imm = 0, all memory controls 0, reg_write = 1.
- 000 sub 00/01/10/11: AND/SLT/OR/JR, alu_op 0/1/2/3. SLT uses rt = [3:2]+8. JR sets reg_write = 0.
- 001 sub 00 LW: alu_op 6, rd = [3:2], mem_read = mem2reg = 1.
- 001 sub 01 SW: alu_op 6, mem_write = 1, reg_write = 0.
- 001 sub 1x: NOP.
- 010 ADD / 101 SUB: alu_op 4 / 5, rd = [1:0]+8.
- 011 ADDI: alu_op 4, rd = [3:2], imm = [1:0], sel_imm = 1.
- 100 TR: alu_op 6, rs = [2:0]+4, rd = [5:3].
- 110 BEQ: alu_op 7, reg_write = 0.
- 111 sub 00/01/10: SRL/SRA/SLL, alu_op 8/9/10, rd = rs.
- 111 sub 11: HALT.
- NOP and HALT: alu_op 0, reg_write = 0, all addresses 0. They still produce out_valid.
- Reads rt: AND, SLT, OR, ADD, SUB, SW, BEQ, shifts. Reads rs: everything except NOP/HALT.
- Accept = instr_valid & instr_ready. On accept, the output register loads the decode and out_valid = 1.
- If out_valid & out_ready and there is no accept, out_valid clears.
- instr_ready = !halted & !hazard & (!out_valid | out_ready).
- hazard (macro on only) = out_valid & mem_read (held LW) & incoming instr_valid & (reads rs and rs == held rd, or reads rt and rt == held rd).
  - Holds for exactly the cycle(s) the LW remains in the output register or is leaving it.
  - After the LW leaves, a one-cycle bubble (out_valid = 0) precedes the dependent instruction.
- stall_count increments on each cycle with hazard = 1 and saturates at all-ones.
- HALT accepted → halted = 1 next cycle. instr_ready stays 0 until reset. The HALT entry itself still drains to execute.

## Timing
- Reset (async assert, sync deassert assumed upstream): out_valid = 0, all control/address/imm outputs 0, alu_op = 0, halted = 0, stall_count = 0.
- Latency: accept in cycle N → fields valid with out_valid in cycle N+1.
- Throughput: 1 instruction/cycle when out_ready = 1 and there is no hazard.
- Back-pressure: out_ready = 0 with out_valid = 1 → output register and fields held stable; instr_ready = 0.
- Simultaneous drain and accept in the same cycle → new entry replaces the old one with no bubble.
- Reset mid-stream discards the held entry immediately.

## Configuration
- DECODE_LOAD_USE_INTERLOCK_EN defined: hazard logic active and stall_count counts.
- Not defined: hazard is tied to 0, stall_count is constant 0, and the pipeline never inserts bubbles. Dependent instructions then rely on the execute-stage forwarding path.

## Test plan
- Reset with rst_n = 0 mid-transfer → out_valid = 0, halted = 0, stall_count = 0 in the same cycle.
- Stream ADD 9'b010_01_10_11 then SUB 9'b101_00_01_00 with out_ready = 1 → back-to-back out_valid. First output: alu_op 4, rs 5, rt 2, rd 11. Second: alu_op 5, rd 8.
- ADDI 9'b011_10_01_11 → sel_imm = 1, imm = 3, rs 6, rd 1.
- out_ready = 0 for 3 cycles with valid input → fields stable, instr_ready = 0. Release → next instruction appears one cycle later.
- LW 9'b001_00_10_00 (rd 2) followed by AND with rt = 2, macro on → one bubble cycle, stall_count = 1. With the macro off → no bubble.
- HALT 9'b111_000_011 followed by valid ADDs → HALT drains, halted = 1, instr_ready stays 0 for 10 cycles, no further out_valid.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// Parameters must match the decode_stage instance they connect to.
interface decode_stage_if #(
    parameter int REG_WIDTH   = 8,
    parameter int NUM_REGS    = 12,
    parameter int STALL_CNT_W = 16
);
    localparam int RA_W = $clog2(NUM_REGS);

    logic                   instr_valid;
    logic [8:0]             instruction;
    logic                   instr_ready;
    logic                   out_ready;
    logic                   out_valid;
    logic [3:0]             alu_op;
    logic [RA_W-1:0]        rs_addr;
    logic [RA_W-1:0]        rt_addr;
    logic [RA_W-1:0]        rd_addr;
    logic [REG_WIDTH-1:0]   imm;
    logic                   reg_write;
    logic                   sel_imm;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem2reg;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output instr_valid, instruction, out_ready,
        input  instr_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_write, sel_imm, mem_read, mem_write, mem2reg, halted, stall_count
    );

    modport slave (
        input  instr_valid, instruction, out_ready,
        output instr_ready, out_valid, alu_op, rs_addr, rt_addr, rd_addr, imm,
               reg_write, sel_imm, mem_read, mem_write, mem2reg, halted, stall_count
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage for the 9-bit accumulator core: one-entry output register,
// sticky halt, and a load-use interlock enabled by DECODE_LOAD_USE_INTERLOCK_EN.
module decode_stage #(
    parameter int REG_WIDTH   = 8,
    parameter int NUM_REGS    = 12,
    parameter int STALL_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam int RA_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [3:0]           alu_op;
        logic [RA_W-1:0]      rs;
        logic [RA_W-1:0]      rt;
        logic [RA_W-1:0]      rd;
        logic [REG_WIDTH-1:0] imm;
        logic                 reg_write;
        logic                 sel_imm;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem2reg;
    } ctrl_t;

    function automatic logic is_halt(input logic [8:0] ins);
        return (ins[8:6] == 3'b111) && (ins[1:0] == 2'b11);
    endfunction

    function automatic ctrl_t decode(input logic [8:0] ins);
        ctrl_t d;
        d           = '0;
        d.rs        = RA_W'(ins[5:4]) + RA_W'(4);
        d.rt        = RA_W'(ins[3:2]);
        d.rd        = RA_W'(11);
        d.reg_write = 1'b1;
        case (ins[8:6])
            3'b000: begin
                d.alu_op = 4'(ins[1:0]);
                if (ins[1:0] == 2'b01) d.rt = RA_W'(ins[3:2]) + RA_W'(8);
                if (ins[1:0] == 2'b11) d.reg_write = 1'b0;
            end
            3'b001: begin
                if (ins[1]) begin
                    d = '0;
                end else begin
                    d.alu_op    = 4'd6;
                    d.mem_read  = !ins[0];
                    d.mem2reg   = !ins[0];
                    d.mem_write = ins[0];
                    d.reg_write = !ins[0];
                    if (!ins[0]) d.rd = RA_W'(ins[3:2]);
                end
            end
            3'b010, 3'b101: begin
                d.alu_op = ins[8] ? 4'd5 : 4'd4;
                d.rd     = RA_W'(ins[1:0]) + RA_W'(8);
            end
            3'b011: begin
                d.alu_op  = 4'd4;
                d.rd      = RA_W'(ins[3:2]);
                d.imm     = REG_WIDTH'(ins[1:0]);
                d.sel_imm = 1'b1;
            end
            3'b100: begin
                d.alu_op = 4'd6;
                d.rs     = RA_W'(ins[2:0]) + RA_W'(4);
                d.rd     = RA_W'(ins[5:3]);
            end
            3'b110: begin
                d.alu_op    = 4'd7;
                d.reg_write = 1'b0;
            end
            default: begin
                if (ins[1:0] == 2'b11) begin
                    d = '0;
                end else begin
                    d.alu_op = 4'd8 + 4'(ins[1:0]);
                    d.rd     = d.rs;
                end
            end
        endcase
        return d;
    endfunction

    // Stage p0: combinational decode of the presented instruction
    ctrl_t                  dec_p0;
    logic                   accept_p0;
    logic                   hazard_p0;
    // Stage p1: output register
    ctrl_t                  dec_p1;
    logic                   vld_p1;
    logic                   halted_p1;
    logic [STALL_CNT_W-1:0] stall_p1;

    assign dec_p0      = decode(bus.instruction);
    assign bus.instr_ready = !halted_p1 && !hazard_p0 && (!vld_p1 || bus.out_ready);
    assign accept_p0   = bus.instr_valid && bus.instr_ready;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    function automatic logic reads_rs(input logic [8:0] ins);
        return !((ins[8:6] == 3'b001) && ins[1]) && !is_halt(ins);
    endfunction

    function automatic logic reads_rt(input logic [8:0] ins);
        case (ins[8:6])
            3'b000, 3'b111:         return ins[1:0] != 2'b11;
            3'b001:                 return ins[1:0] == 2'b01;
            3'b010, 3'b101, 3'b110: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A held LW whose destination feeds the incoming instruction blocks it until a bubble
    assign hazard_p0 = vld_p1 && dec_p1.mem_read && bus.instr_valid &&
                       ((reads_rs(bus.instruction) && (dec_p0.rs == dec_p1.rd)) ||
                        (reads_rt(bus.instruction) && (dec_p0.rt == dec_p1.rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         stall_p1 <= '0;
        else if (hazard_p0) stall_p1 <= sat_inc(stall_p1);
    end
`else
    assign hazard_p0 = 1'b0;
    assign stall_p1  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            dec_p1    <= '0;
            halted_p1 <= 1'b0;
        end else begin
            if (accept_p0) begin
                vld_p1 <= 1'b1;
                dec_p1 <= dec_p0;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (accept_p0 && is_halt(bus.instruction)) halted_p1 <= 1'b1;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.alu_op      = dec_p1.alu_op;
    assign bus.rs_addr     = dec_p1.rs;
    assign bus.rt_addr     = dec_p1.rt;
    assign bus.rd_addr     = dec_p1.rd;
    assign bus.imm         = dec_p1.imm;
    assign bus.reg_write   = dec_p1.reg_write;
    assign bus.sel_imm     = dec_p1.sel_imm;
    assign bus.mem_read    = dec_p1.mem_read;
    assign bus.mem_write   = dec_p1.mem_write;
    assign bus.mem2reg     = dec_p1.mem2reg;
    assign bus.halted      = halted_p1;
    assign bus.stall_count = stall_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, handshake corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] imm;
        logic       rw;
        logic       sel;
        logic       mr;
        logic       mw;
        logic       m2r;
    } fields_t;

    typedef struct packed {
        logic [8:0] ins;
        fields_t    f;
    } vec_t;

    typedef enum int {
        M_AND, M_SLT, M_OR, M_JR, M_LW, M_SW, M_NOP, M_ADD, M_SUB,
        M_ADDI, M_TR, M_BEQ, M_SRL, M_SRA, M_SLL, M_HALT
    } mn_t;

    function automatic mn_t classify(input logic [8:0] i);
        logic [1:0] s;
        s = i[1:0];
        case (i[8:6])
            3'b000:  return (s == 0) ? M_AND : (s == 1) ? M_SLT : (s == 2) ? M_OR : M_JR;
            3'b001:  return (s == 0) ? M_LW : (s == 1) ? M_SW : M_NOP;
            3'b010:  return M_ADD;
            3'b011:  return M_ADDI;
            3'b100:  return M_TR;
            3'b101:  return M_SUB;
            3'b110:  return M_BEQ;
            default: return (s == 0) ? M_SRL : (s == 1) ? M_SRA : (s == 2) ? M_SLL : M_HALT;
        endcase
    endfunction

    function automatic fields_t ref_fields(input logic [8:0] i);
        fields_t    f;
        mn_t        m;
        logic [3:0] b54, b32, b10;
        m   = classify(i);
        b54 = {2'b00, i[5:4]};
        b32 = {2'b00, i[3:2]};
        b10 = {2'b00, i[1:0]};
        f = '0;
        f.rs = b54 + 4'd4;
        f.rt = b32;
        f.rd = 4'd11;
        f.rw = 1'b1;
        case (m)
            M_AND:  f.alu = 4'd0;
            M_SLT:  begin f.alu = 4'd1; f.rt = b32 + 4'd8; end
            M_OR:   f.alu = 4'd2;
            M_JR:   begin f.alu = 4'd3; f.rw = 1'b0; end
            M_LW:   begin f.alu = 4'd6; f.rd = b32; f.mr = 1'b1; f.m2r = 1'b1; end
            M_SW:   begin f.alu = 4'd6; f.mw = 1'b1; f.rw = 1'b0; end
            M_ADD:  begin f.alu = 4'd4; f.rd = b10 + 4'd8; end
            M_SUB:  begin f.alu = 4'd5; f.rd = b10 + 4'd8; end
            M_ADDI: begin f.alu = 4'd4; f.rd = b32; f.imm = {6'b0, i[1:0]}; f.sel = 1'b1; end
            M_TR:   begin f.alu = 4'd6; f.rs = {1'b0, i[2:0]} + 4'd4; f.rd = {1'b0, i[5:3]}; end
            M_BEQ:  begin f.alu = 4'd7; f.rw = 1'b0; end
            M_SRL:  begin f.alu = 4'd8;  f.rd = f.rs; end
            M_SRA:  begin f.alu = 4'd9;  f.rd = f.rs; end
            M_SLL:  begin f.alu = 4'd10; f.rd = f.rs; end
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic ref_reads_rs(input logic [8:0] i);
        return !(classify(i) inside {M_NOP, M_HALT});
    endfunction

    function automatic logic ref_reads_rt(input logic [8:0] i);
        return classify(i) inside {M_AND, M_SLT, M_OR, M_ADD, M_SUB, M_SW, M_BEQ, M_SRL, M_SRA, M_SLL};
    endfunction

    function automatic fields_t dut_fields();
        return {bus.alu_op, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.imm,
                bus.reg_write, bus.sel_imm, bus.mem_read, bus.mem_write, bus.mem2reg};
    endfunction

    function automatic vec_t mk(input logic [8:0] ins, input int alu, input int rs, input int rt,
                                input int rd, input int imm, input bit rw, input bit sel,
                                input bit mr, input bit mw, input bit m2r);
        vec_t v;
        v.ins = ins;
        v.f   = {4'(alu), 4'(rs), 4'(rt), 4'(rd), 8'(imm), rw, sel, mr, mw, m2r};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0] I_ADD  = 9'b010_01_10_11;
    localparam logic [8:0] I_SUB  = 9'b101_00_01_00;
    localparam logic [8:0] I_ADDI = 9'b011_10_01_11;
    localparam logic [8:0] I_LW   = 9'b001_00_10_00;
    localparam logic [8:0] I_AND  = 9'b000_00_10_00;
    localparam logic [8:0] I_HALT = 9'b111_000_011;

    vec_t             tbl[12];
    fields_t          q[$];
    fields_t          f_in;
    logic [15:0]      exp_stall;
    logic [8:0]       ins;
    logic             iv, ordy, haz, rdy;

    initial begin
        tbl[0]  = mk(I_ADD,          4, 5,  2, 11, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(I_SUB,          5, 4,  1,  8, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(I_ADDI,         4, 6,  1,  1, 3, 1, 1, 0, 0, 0);
        tbl[3]  = mk(I_LW,           6, 4,  2,  2, 0, 1, 0, 1, 0, 1);
        tbl[4]  = mk(9'b001_11_01_01, 6, 7,  1, 11, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(9'b000_10_11_01, 1, 6, 11, 11, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(9'b000_01_00_11, 3, 5,  0, 11, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(9'b100_101_110,  6, 10, 3,  5, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(9'b110_00_11_10, 7, 4,  3, 11, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(9'b111_11_00_01, 9, 7,  0,  7, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(9'b111_00_10_10, 10, 4, 2,  4, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(9'b001_10_11_10, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.out_ready   = 1'b1;
        tick();
        tick();
        chk("rst_vld",    32'(bus.out_valid), 0);
        chk("rst_fields", 32'(dut_fields()), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_stall",  32'(bus.stall_count), 0);
        #2 rst_n = 1'b1;
        tick();

        // Decode table, one instruction at a time with an idle cycle between
        for (int k = 0; k < 12; k++) begin
            bus.instr_valid = 1'b1;
            bus.instruction = tbl[k].ins;
            tick();
            bus.instr_valid = 1'b0;
            chk("tbl_vld",    32'(bus.out_valid), 1);
            chk("tbl_fields", 32'(dut_fields()), 32'(tbl[k].f));
            tick();
            chk("tbl_drain",  32'(bus.out_valid), 0);
        end

        // Back-to-back ADD then SUB
        bus.instr_valid = 1'b1;
        bus.instruction = I_ADD;
        tick();
        chk("b2b_vld0", 32'(bus.out_valid), 1);
        chk("b2b_add",  32'(dut_fields()), 32'(tbl[0].f));
        bus.instruction = I_SUB;
        #1 chk("b2b_rdy", 32'(bus.instr_ready), 1);
        tick();
        chk("b2b_vld1", 32'(bus.out_valid), 1);
        chk("b2b_sub",  32'(dut_fields()), 32'(tbl[1].f));
        bus.instr_valid = 1'b0;
        tick();

        // Back-pressure for three cycles
        bus.instr_valid = 1'b1;
        bus.instruction = I_ADDI;
        tick();
        bus.instruction = I_SUB;
        bus.out_ready   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_rdy", 32'(bus.instr_ready), 0);
            tick();
            chk("bp_vld",    32'(bus.out_valid), 1);
            chk("bp_fields", 32'(dut_fields()), 32'(tbl[2].f));
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(bus.instr_ready), 1);
        tick();
        bus.instr_valid = 1'b0;
        chk("bp_next_vld", 32'(bus.out_valid), 1);
        chk("bp_next",     32'(dut_fields()), 32'(tbl[1].f));
        tick();

        // Load-use: LW r2 then AND reading r2
        bus.instr_valid = 1'b1;
        bus.instruction = I_LW;
        tick();
        bus.instruction = I_AND;
        #1 chk("lu_rdy", 32'(bus.instr_ready), 32'(!IL));
        tick();
        chk("lu_bubble", 32'(bus.out_valid), 32'(!IL));
        chk("lu_stall",  32'(bus.stall_count), 32'(IL));
        bus.instr_valid = IL;
        tick();
        bus.instr_valid = 1'b0;
        chk("lu_vld2",   32'(bus.out_valid), 32'(IL));
        chk("lu_and",    32'(dut_fields()), 32'(ref_fields(I_AND)));
        tick();
        chk("lu_idle",   32'(bus.out_valid), 0);

        // Randomized traffic against the queue model
        exp_stall = {15'b0, IL};
        for (int c = 0; c < 600; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ins  = 9'($urandom);
            if (classify(ins) == M_HALT) ins[0] = 1'b0;
            bus.instr_valid = iv;
            bus.instruction = ins;
            bus.out_ready   = ordy;
            #1;
            f_in = ref_fields(ins);
            haz  = IL && (q.size() > 0) && q[0].mr && iv &&
                   ((ref_reads_rs(ins) && f_in.rs == q[0].rd) ||
                    (ref_reads_rt(ins) && f_in.rt == q[0].rd));
            rdy  = !haz && ((q.size() == 0) || ordy);
            chk("rnd_rdy", 32'(bus.instr_ready), 32'(rdy));
            if (haz && exp_stall != 16'hFFFF) exp_stall++;
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(f_in);
            tick();
            chk("rnd_vld", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_fields", 32'(dut_fields()), 32'(q[0]));
            chk("rnd_stall", 32'(bus.stall_count), 32'(exp_stall));
        end

        // Reset while an entry is held under back-pressure
        bus.instr_valid = 1'b1;
        bus.instruction = I_ADD;
        bus.out_ready   = 1'b0;
        #1;
        bus.instr_valid = bus.instr_ready;
        tick();
        bus.instr_valid = 1'b0;
        chk("mid_vld_before", 32'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",    32'(bus.out_valid), 0);
        chk("mid_rst_halted", 32'(bus.halted), 0);
        chk("mid_rst_stall",  32'(bus.stall_count), 0);
        chk("mid_rst_fields", 32'(dut_fields()), 0);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // HALT drains, then the stage refuses everything
        bus.instr_valid = 1'b1;
        bus.instruction = I_HALT;
        tick();
        chk("halt_vld",    32'(bus.out_valid), 1);
        chk("halt_fields", 32'(dut_fields()), 0);
        chk("halt_flag",   32'(bus.halted), 1);
        bus.instruction = I_ADD;
        for (int c = 0; c < 10; c++) begin
            #1 chk("halt_rdy", 32'(bus.instr_ready), 0);
            tick();
            chk("halt_novld", 32'(bus.out_valid), 0);
            chk("halt_sticky", 32'(bus.halted), 1);
        end
        bus.instr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("halt_rst", 32'(bus.halted), 0);
        #2 rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
